// File: rtl/fp_mul_arb_pkg.sv
// Shared constants and helpers for the fp_mul arbiter slice.
package fp_mul_arb_pkg;
  localparam int FP_WIDTH = 32;
  localparam logic [FP_WIDTH-1:0] FP_ZERO = 32'h0000_0000;
  localparam logic [FP_WIDTH-1:0] FP_ONE  = 32'h3F80_0000;

  // A single requester still needs a 1-bit tag so the port exists.
  function automatic int id_width(input int num_req);
    return (num_req <= 1) ? 1 : $clog2(num_req);
  endfunction
endpackage

// File: rtl/fp_mul.sv
// Combinational IEEE-754 single-precision multiply, round-to-nearest-even.
// Subnormal inputs and results flush to signed zero; NaN results are canonical quiet NaN.
module fp_mul (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic        sign, norm, guard, sticky, rnd;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [47:0] prod;
  logic [22:0] frac;
  logic [23:0] frac_r;
  logic [9:0]  e_sum;

  always_comb begin
    sign   = a[31] ^ b[31];
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    prod   = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    norm   = prod[47];
    if (norm) begin
      frac   = prod[46:24];
      guard  = prod[23];
      sticky = |prod[22:0];
    end else begin
      frac   = prod[45:23];
      guard  = prod[22];
      sticky = |prod[21:0];
    end
    rnd    = guard & (sticky | frac[0]);
    frac_r = {1'b0, frac} + {23'd0, rnd};
    // Biased sum kept unsigned: exponent field = e_sum - 127.
    e_sum  = {2'b00, a[30:23]} + {2'b00, b[30:23]} + {9'd0, norm} + {9'd0, frac_r[23]};

    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
      y = 32'h7FC0_0000;
    else if (a_inf || b_inf)
      y = {sign, 8'hFF, 23'd0};
    else if (a_zero || b_zero || (e_sum <= 10'd127))
      y = {sign, 31'd0};
    else if (e_sum >= 10'd382)
      y = {sign, 8'hFF, 23'd0};
    else
      y = {sign, 8'(e_sum - 10'd127), frac_r[22:0]};
  end
endmodule

// File: rtl/fp_mul_arbiter_rr.sv
// Requester arbiter: round-robin from ptr with wrap, or lowest index wins
// when FP_MUL_ARB_FIXED_PRIO_EN is defined (ptr is then ignored).
module rr_arbiter
  import fp_mul_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  input  logic                en,
  output logic [NUM_REQ-1:0]  grant,
  output logic [ID_WIDTH-1:0] idx,
  output logic                found
);
`ifdef FP_MUL_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
`endif

  always_comb begin
    int cand;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef FP_MUL_ARB_FIXED_PRIO_EN
      cand = k;
`else
      cand = (int'(ptr) + k) % NUM_REQ;
`endif
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = ID_WIDTH'(cand);
      end
    end
    grant[idx] = found & en;
  end
endmodule

// File: rtl/fp_mul_arbiter.sv
// Shares one combinational fp_mul among NUM_REQ requesters through an operand and a result register.
// Optional FP_MUL_ARB_FIXED_PRIO_EN selects fixed-priority grant instead of round-robin.
module fp_mul_arbiter
  import fp_mul_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = FP_WIDTH,
  parameter int ID_WIDTH   = id_width(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [DATA_WIDTH-1:0]         res_data,
  output logic [ID_WIDTH-1:0]           res_id
);
  logic                  op_valid;
  logic [DATA_WIDTH-1:0] op_a, op_b, mul_out;
  logic [ID_WIDTH-1:0]   op_id, rr_ptr, gnt_idx;
  logic                  gnt_any, advance, op_load, accept;

  assign advance = !res_valid || res_ready;
  assign op_load = !op_valid || advance;
  assign accept  = gnt_any && op_load && !rst;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .en    (op_load && !rst),
    .grant (req_ready),
    .idx   (gnt_idx),
    .found (gnt_any)
  );

  fp_mul u_mul (
    .a (op_a),
    .b (op_b),
    .y (mul_out)
  );

`ifdef FP_MUL_ARB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  always_ff @(posedge clk) begin
    if (rst)
      rr_ptr <= '0;
    else if (accept)
      rr_ptr <= (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      op_valid  <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      op_id     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
    end else begin
      if (op_load) begin
        op_valid <= accept;
        if (accept) begin
          op_a  <= req_a[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
          op_b  <= req_b[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
          op_id <= gnt_idx;
        end
      end
      // Result register shifts whenever downstream has room, valid or not.
      if (advance) begin
        res_valid <= op_valid;
        res_data  <= mul_out;
        res_id    <= op_id;
      end
    end
  end
endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Scoreboard bench for fp_mul_arbiter: expected {id, product} queued at accept, compared at result handshake.
module tb_fp_mul_arbiter;
  import fp_mul_arb_pkg::*;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_a, req_b;
  logic            res_valid, res_ready;
  logic [DW-1:0]   res_data;
  logic [IW-1:0]   res_id;

  always #5 clk = ~clk;

  fp_mul_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id)
  );

  logic [IW+DW-1:0] sb[$];
  int               acc_q[$];
  logic [DW-1:0]    prod_tab[N];
  logic [N-1:0]     hs_req;
  logic             got_res, one_shot;
  logic [IW+DW-1:0] cap_res, exp_res;
  int               checks = 0, errors = 0;

  task automatic set_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] p);
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
    prod_tab[i] = p;
  endtask

  // One clock: sample handshakes before the edge, queue expectations after it.
  task automatic step();
    #2;
    hs_req  = req_valid & req_ready;
    got_res = res_valid & res_ready;
    cap_res = {res_id, res_data};
    exp_res = 'x;
    if (got_res && sb.size() > 0) exp_res = sb.pop_front();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs_req[i]) begin
        sb.push_back({IW'(i), prod_tab[i]});
        acc_q.push_back(i);
        if (one_shot) req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    acc_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '1;
    res_ready = 1'b1;
    step();
    step();
    #2;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got=%b want=0000", req_ready); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got=%b want=0", res_valid); end
    checks++; if (res_data !== FP_ZERO) begin errors++; $display("FAIL reset_res_data got=%h want=%h", res_data, FP_ZERO); end
    checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL reset_res_id got=%0d want=0", res_id); end
    req_valid = '0;
    rst = 1'b0;
    step();
    sb.delete();
    acc_q.delete();
  endtask

  task automatic test_single_op();
    int nres;
    set_op(0, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);
    one_shot = 1'b1;
    res_ready = 1'b1;
    req_valid = 4'b0001;
    step();
    checks++; if (acc_q.size() != 1) begin errors++; $display("FAIL single_accept got=%0d accepts want=1", acc_q.size()); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_early got=%b want=0", res_valid); end
    step();
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL single_latency got=%b want=1", res_valid); end
    nres = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (got_res) begin
        nres++;
        checks++; if (cap_res !== exp_res) begin errors++; $display("FAIL single_result got=%h want=%h", cap_res, exp_res); end
      end
    end
    checks++; if (nres != 1 || sb.size() != 0) begin errors++; $display("FAIL single_count got=%0d results, %0d pending want=1,0", nres, sb.size()); end
  endtask

  task automatic test_round_robin();
    int nres, first_c, last_c;
    pulse_reset();
    set_op(0, FP_ONE, 32'h4000_0000, 32'h4000_0000);
    set_op(1, FP_ONE, 32'h4040_0000, 32'h4040_0000);
    set_op(2, FP_ONE, 32'h4080_0000, 32'h4080_0000);
    set_op(3, FP_ONE, 32'h40A0_0000, 32'h40A0_0000);
    one_shot = 1'b0;
    res_ready = 1'b1;
    req_valid = '1;
    nres = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 12; c++) begin
      if (c == 6) req_valid = '0;
      step();
      if (got_res) begin
        nres++;
        if (first_c < 0) first_c = c;
        last_c = c;
        checks++; if (cap_res !== exp_res) begin errors++; $display("FAIL rr_result got=%h want=%h", cap_res, exp_res); end
      end
    end
    checks++; if (acc_q.size() != 6) begin errors++; $display("FAIL rr_accept_count got=%0d want=6", acc_q.size()); end
    for (int k = 0; k < 6 && k < acc_q.size(); k++) begin
      checks++; if (acc_q[k] != k % 4) begin errors++; $display("FAIL rr_order[%0d] got=%0d want=%0d", k, acc_q[k], k % 4); end
    end
    checks++; if (nres != 6 || first_c != 2 || last_c != 7) begin
      errors++; $display("FAIL rr_throughput got=%0d results cycles %0d..%0d want=6 results cycles 2..7", nres, first_c, last_c);
    end
  endtask

  task automatic test_backpressure();
    int nres;
    // Pointer sits at 2 after the round-robin run.
    set_op(2, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000);
    set_op(3, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000);
    set_op(0, FP_ONE, FP_ONE, FP_ONE);
    acc_q.delete();
    one_shot = 1'b1;
    res_ready = 1'b0;
    req_valid = 4'b1100;
    step();
    step();
    req_valid = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_req_ready got=%b want=0000", req_ready); end
      checks++; if (res_valid !== 1'b1 || res_data !== 32'h4010_0000 || res_id !== 2'd2) begin
        errors++; $display("FAIL bp_hold got=%b/%h/%0d want=1/40100000/2", res_valid, res_data, res_id);
      end
      step();
    end
    res_ready = 1'b1;
    nres = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (got_res) begin
        nres++;
        checks++; if (cap_res !== exp_res) begin errors++; $display("FAIL bp_result got=%h want=%h", cap_res, exp_res); end
      end
    end
    checks++; if (nres != 3 || sb.size() != 0) begin errors++; $display("FAIL bp_count got=%0d results, %0d pending want=3,0", nres, sb.size()); end
    checks++; if (acc_q.size() != 3 || acc_q[0] != 2 || acc_q[1] != 3 || acc_q[2] != 0) begin
      errors++; $display("FAIL bp_order got=%0d accepts want=2,3,0", acc_q.size());
    end
  endtask

  task automatic test_zero_operand();
    int nres;
    set_op(2, FP_ZERO, 32'h4040_0000, FP_ZERO);
    acc_q.delete();
    one_shot = 1'b1;
    res_ready = 1'b1;
    req_valid = 4'b0100;
    nres = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (got_res) begin
        nres++;
        checks++; if (cap_res !== {2'd2, FP_ZERO}) begin errors++; $display("FAIL zero_result got=%h want=%h", cap_res, {2'd2, FP_ZERO}); end
      end
    end
    checks++; if (nres != 1 || sb.size() != 0) begin errors++; $display("FAIL zero_count got=%0d results want=1", nres); end
  endtask

  task automatic test_reset_mid_flight();
    int nres;
    set_op(0, FP_ONE, 32'h4040_0000, 32'h4040_0000);
    set_op(1, 32'h4000_0000, FP_ONE, 32'h4000_0000);
    one_shot = 1'b1;
    res_ready = 1'b0;
    req_valid = 4'b0011;
    step();
    step();
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL rmid_fill got=%b want=1", res_valid); end
    pulse_reset();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rmid_after_rst got=%b want=0", res_valid); end
    res_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rmid_stale got=%b want=0", res_valid); end
    end
    set_op(2, 32'h4080_0000, 32'h3F00_0000, 32'h4000_0000);
    set_op(3, 32'hBF80_0000, 32'h4040_0000, 32'hC040_0000);
    req_valid = '1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rmid_first_grant got=%b want=0001", req_ready); end
    nres = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (got_res) begin
        nres++;
        checks++; if (cap_res !== exp_res) begin errors++; $display("FAIL rmid_result got=%h want=%h", cap_res, exp_res); end
      end
    end
    checks++; if (nres != 4 || sb.size() != 0) begin errors++; $display("FAIL rmid_count got=%0d results want=4", nres); end
    checks++; if (acc_q.size() != 4 || acc_q[0] != 0 || acc_q[3] != 3) begin errors++; $display("FAIL rmid_order got=%0d accepts want=0,1,2,3", acc_q.size()); end
  endtask

`ifdef FP_MUL_ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    pulse_reset();
    set_op(1, FP_ONE, FP_ONE, FP_ONE);
    set_op(3, FP_ONE, FP_ONE, FP_ONE);
    one_shot = 1'b0;
    res_ready = 1'b1;
    req_valid = 4'b1010;
    for (int c = 0; c < 4; c++) step();
    req_valid = 4'b1000;
    for (int c = 0; c < 2; c++) step();
    req_valid = '0;
    for (int c = 0; c < 4; c++) step();
    checks++; if (acc_q.size() != 6) begin errors++; $display("FAIL fp_count got=%0d want=6", acc_q.size()); end
    for (int k = 0; k < 6 && k < acc_q.size(); k++) begin
      checks++; if (acc_q[k] != ((k < 4) ? 1 : 3)) begin errors++; $display("FAIL fp_order[%0d] got=%0d want=%0d", k, acc_q[k], (k < 4) ? 1 : 3); end
    end
    sb.delete();
  endtask
`endif

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    res_ready = 1'b0;
    one_shot = 1'b1;
    for (int i = 0; i < N; i++) prod_tab[i] = FP_ZERO;
    test_reset();
    test_single_op();
`ifdef FP_MUL_ARB_FIXED_PRIO_EN
    test_fixed_prio();
    pulse_reset();
    set_op(0, FP_ONE, FP_ONE, FP_ONE);
    req_valid = 4'b0011;
    one_shot = 1'b1;
    for (int c = 0; c < 6; c++) step();
    sb.delete();
`else
    test_round_robin();
`endif
    test_backpressure();
    test_zero_operand();
    test_reset_mid_flight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fp_mul_arbiter.md
Name: fp_mul_arbiter

Overview:
- Shares one combinational single-precision fp_mul instance among NUM_REQ requesters, such as the softmax exp/normalise lanes.
- Round-robin grant with per-requester valid/ready handshake.
- Two-stage pipeline: an operand register feeds fp_mul, and fp_mul feeds a result register.
- The result is returned with the originating requester ID under valid/ready backpressure.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 32, IEEE-754 single-precision operand and result width.
- ID_WIDTH, $clog2(NUM_REQ), width of the requester tag.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  NUM_REQ*DATA_WIDTH  operand A; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_b  in  NUM_REQ*DATA_WIDTH  operand B; same packing as req_a.
- res_valid  out  1  result valid.
- res_ready  in  1  downstream accepts the result.
- res_data  out  DATA_WIDTH  product A*B as produced by fp_mul.
- res_id  out  ID_WIDTH  index of the requester that issued the operation.

Behaviour:
- Reset values (on clk edge with rst=1):
  - op_valid=0, res_valid=0, res_data=0, res_id=0, rr_ptr=0.
  - req_ready is all zero during reset.
- Advance rules:
  - advance = !res_valid || res_ready.
  - op_load = !op_valid || advance.
- Grant:
  - Combinational round-robin over req_valid, searching from rr_ptr upward with wrap.
  - req_ready[g] = op_load for the granted g; all other bits are 0.
  - req_ready may depend on req_valid.
- Accept: when req_valid[g] && req_ready[g]:
  - op_a/op_b/op_id <= req_a[g]/req_b[g]/g, and op_valid <= 1.
  - rr_ptr <= (g+1) mod NUM_REQ.
- rr_ptr changes only on an accepted handshake.
- If op_load=1 and no request is valid, op_valid <= 0.
- Result stage: when advance:
  - res_valid <= op_valid.
  - res_data <= fp_mul(op_a, op_b).
  - res_id <= op_id.
- When not advancing, res_data and res_id hold stable.
- Latency: accept at edge t gives res_valid=1 after edge t+1, i.e. two clocks from request presentation. Throughput is 1 op/cycle when res_ready=1.
- Capacity: at most 2 ops in flight. With res_valid=1 and res_ready=0 and op_valid=1, req_ready is all zero.
- Simultaneous res handshake and new accept in the same cycle is legal and lossless; the pipeline shifts.
- A requester holding req_valid keeps its operands stable until accepted. The arbiter never drops or reorders ops, so results leave in accept order.
- Arithmetic is entirely delegated to fp_mul. The block neither inspects nor modifies values; special values pass through.
- NUM_REQ=1 degenerates to a plain 2-stage pipeline with res_id=0.
- rst asserted mid-operation discards all in-flight ops, with no result emitted. rr_ptr returns to 0.

Optional Feature:
- Macro: FP_MUL_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, where the lowest asserted index always wins. rr_ptr is not implemented, and starvation of high indices is permitted.
- Undefined (default): round-robin as specified above.
- Ports and latency are identical in both builds.

Decomposition:
- Package fp_mul_arb_pkg holds:
  - FP_WIDTH=32.
  - Constants FP_ZERO=32'h00000000 and FP_ONE=32'h3F800000 for benches.
  - Helper function for requester tag width.
- Sub-module rr_arbiter(NUM_REQ): inputs req vector, ptr and enable; outputs one-hot grant and encoded index.
  - The fixed-priority macro lives inside this sub-module.
- fp_mul is the existing combinational multiplier, instantiated unchanged.

Test Plan:
- Single op: req 0 with A=0x40000000, B=0x40400000, res_ready=1 -> res_valid two clocks later, res_data=0x40C00000, res_id=0.
- Round-robin: all 4 req_valid held, distinct operands, res_ready=1 -> accept order 0,1,2,3,0,1; one result per cycle; res_id follows the same order.
- Backpressure: fill the pipeline, then res_ready=0 for 3 cycles -> res_data/res_id stable, req_ready=0 after 2 ops in flight; on release all ops arrive in order with none lost. Example: A=B=0x3FC00000 gives 0x40100000.
- Zero operands: A=0x00000000, B=0x40400000 from req 2 -> res_data=0x00000000, res_id=2.
- Reset mid-flight: two ops in flight, rst=1 for 1 cycle -> res_valid=0 next cycle, no stale result afterwards, next grant from index 0.
- With FP_MUL_ARB_FIXED_PRIO_EN: reqs 1 and 3 held -> req 1 is granted on every cycle until it drops; only then req 3 is granted.
